// File: rtl/alu_md_pkg.sv
// Shared encodings for the multi-cycle execute unit: base-op selects,
// M-extension funct3 codes and the control FSM state type.
package alu_md_pkg;

    // Base ALU operation selects (ALUControl); 3'b111 also decodes as shift.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_CMP = 3'b101;
    localparam logic [2:0] ALU_SHF = 3'b110;

    // Compare refinement via funct3.
    localparam logic [2:0] CMP_SLT  = 3'b010;
    localparam logic [2:0] CMP_SLTU = 3'b011;

    // M-extension operations via funct3.
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic md_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/alu_mc_md_md_iter.sv
// Iterative multiply/divide datapath: shift-add multiplier and restoring
// divider on operand magnitudes, one bit per step, plus sign fix-up and
// result select. Sequencing is owned by the parent FSM.
module md_iter
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_start,
    input  logic            i_step,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_bypass,
    output logic            o_cnt_zero,
    output logic [XLEN-1:0] o_result
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic            w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic            w_divz, w_ovf;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic [XLEN:0]   w_mul_sum, w_div_shift, w_div_diff;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0] w_quot, w_rem;

    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_a, r_opnd, r_hi, r_lo;
    logic [SHW-1:0]  r_cnt;
    logic            r_q_neg, r_r_neg, r_divz, r_ovf;

    // Decode signedness, magnitudes and the two short-circuit cases from the live operands.
    always_comb begin
        w_is_div   = md_is_div(i_funct3);
        w_a_signed = w_is_div ? ~i_funct3[0] : (i_funct3 == MD_MULH || i_funct3 == MD_MULHSU);
        w_b_signed = w_is_div ? ~i_funct3[0] : (i_funct3 == MD_MULH);
        w_a_neg    = w_a_signed & i_a[XLEN-1];
        w_b_neg    = w_b_signed & i_b[XLEN-1];
        w_mag_a    = w_a_neg ? -i_a : i_a;
        w_mag_b    = w_b_neg ? -i_b : i_b;
        w_divz     = w_is_div & (i_b == '0);
        w_ovf      = w_is_div & ~i_funct3[0] & (i_a == MIN_VAL) & (i_b == '1);
        o_bypass   = w_divz | w_ovf;
    end

    // One iteration of either algorithm; r_hi/r_lo are shared between them.
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_div_shift = {r_hi, r_lo[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
    end

    // Operand capture on start, then one multiply/divide bit per step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_funct3 <= '0;
            r_a      <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_divz   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (i_start) begin
            r_funct3 <= i_funct3;
            r_a      <= i_a;
            r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
            r_hi     <= '0;
            r_lo     <= w_is_div ? w_mag_a : w_mag_b;
            r_cnt    <= SHW'(XLEN-1);
            r_q_neg  <= w_a_neg ^ w_b_neg;
            r_r_neg  <= w_a_neg;
            r_divz   <= w_divz;
            r_ovf    <= w_ovf;
        end else if (i_step) begin
            r_cnt <= r_cnt - SHW'(1);
            if (!md_is_div(r_funct3)) begin
                r_hi <= w_mul_sum[XLEN:1];
                r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end else if (!w_div_diff[XLEN]) begin
                r_hi <= w_div_diff[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], 1'b1};
            end else begin
                r_hi <= w_div_shift[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign o_cnt_zero = (r_cnt == '0);

    // Sign correction and final result select, consumed by the parent in FIX.
    always_comb begin
        w_prod   = {r_hi, r_lo};
        w_prod_s = r_q_neg ? -w_prod : w_prod;
        w_quot   = r_q_neg ? -r_lo : r_lo;
        w_rem    = r_r_neg ? -r_hi : r_hi;
        o_result = '0;
        if (!md_is_div(r_funct3)) begin
            o_result = (r_funct3 == MD_MUL) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
        end else if (!r_funct3[1]) begin
            o_result = r_divz ? '1 : (r_ovf ? MIN_VAL : w_quot);
        end else begin
            o_result = r_divz ? r_a : (r_ovf ? '0 : w_rem);
        end
    end

endmodule

// File: rtl/alu_mc_md.sv
// EX-stage execute unit: single-cycle base ALU plus iterative M-extension.
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both 1; a result is consumed on a rising edge where out_valid
// and out_ready are both 1. Operands must be stable only in the accept
// cycle, and Result stays stable while out_valid is 1.
module alu_mc_md
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      ALUControl,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            is_md,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output state_t          o_dbg_state
);

    localparam int SHW = $clog2(XLEN);

    state_t          r_state, w_next;
    logic [XLEN-1:0] r_result, w_base, w_md_result;
    logic [SHW-1:0]  w_shamt;
    logic            w_accept, w_bypass, w_cnt_zero;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_shamt  = B[SHW-1:0];

    md_iter #(.XLEN(XLEN)) u_md_iter (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_accept && is_md),
        .i_step     (r_state == BUSY),
        .i_funct3   (funct3),
        .i_a        (A),
        .i_b        (B),
        .o_bypass   (w_bypass),
        .o_cnt_zero (w_cnt_zero),
        .o_result   (w_md_result)
    );

    // Base ALU result, computed from the live operands during the accept cycle.
    always_comb begin
        w_base = '0;
        case (ALUControl)
            ALU_ADD: w_base = A + B;
            ALU_SUB: w_base = A + ~B + XLEN'(1);
            ALU_AND: w_base = A & B;
            ALU_OR:  w_base = A | B;
            ALU_XOR: w_base = A ^ B;
            ALU_CMP: begin
                if (funct3 == CMP_SLT)       w_base = XLEN'($signed(A) < $signed(B));
                else if (funct3 == CMP_SLTU) w_base = XLEN'(A < B);
                else                         w_base = '0;
            end
            default: begin
                if (!funct3[2])    w_base = A << w_shamt;
                else if (funct7_5) w_base = $unsigned($signed(A) >>> w_shamt);
                else               w_base = A >> w_shamt;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; special divide cases skip the iteration phase.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next = !is_md ? DONE : (w_bypass ? FIX : BUSY);
            BUSY: if (w_cnt_zero) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs decode directly from state.
    always_comb begin
        in_ready    = (r_state == IDLE);
        out_valid   = (r_state == DONE);
        o_dbg_state = r_state;
    end

    // Result register: loaded on a base-op accept or at the end of FIX, held otherwise.
    always_ff @(posedge clk) begin
        if (reset)                   r_result <= '0;
        else if (w_accept && !is_md) r_result <= w_base;
        else if (r_state == FIX)     r_result <= w_md_result;
    end

    assign Result = r_result;

endmodule

// File: tb/tb_alu_mc_md.sv
// Directed plus randomized bench for alu_mc_md at XLEN=32 and XLEN=16,
// with an arithmetic reference model feeding an expected-result queue.
module tb_alu_mc_md;
    import alu_md_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, out_ready, f7, md;
    logic [2:0]  alu, f3;
    logic [31:0] a, b;
    int          g_w = 32;

    logic        in_valid32, in_ready32, out_valid32;
    logic [31:0] res32;
    state_t      dbg32;
    logic        in_valid16, in_ready16, out_valid16;
    logic [15:0] res16;
    state_t      dbg16;

    logic        obs_ready, obs_valid;
    logic [31:0] obs_result;
    state_t      obs_state;

    logic [31:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    assign in_valid32 = in_valid && (g_w == 32);
    assign in_valid16 = in_valid && (g_w == 16);
    assign obs_ready  = (g_w == 32) ? in_ready32  : in_ready16;
    assign obs_valid  = (g_w == 32) ? out_valid32 : out_valid16;
    assign obs_result = (g_w == 32) ? res32 : {16'd0, res16};
    assign obs_state  = (g_w == 32) ? dbg32 : dbg16;

    alu_mc_md #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .A(a), .B(b), .ALUControl(alu), .funct3(f3), .funct7_5(f7), .is_md(md),
        .out_valid(out_valid32), .out_ready(out_ready), .Result(res32), .o_dbg_state(dbg32)
    );

    alu_mc_md #(.XLEN(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a[15:0]), .B(b[15:0]), .ALUControl(alu), .funct3(f3), .funct7_5(f7), .is_md(md),
        .out_valid(out_valid16), .out_ready(out_ready), .Result(res16), .o_dbg_state(dbg16)
    );

    // Reference model in wide integer arithmetic, result masked to width w.
    function automatic logic [31:0] model(input int w, input logic [2:0] m_alu, input logic [2:0] m_f3,
                                          input logic m_f7, input logic m_md,
                                          input logic [31:0] m_a, input logic [31:0] m_b);
        longint unsigned msk, ua, ub, r;
        longint sa, sb, p, minv;
        int sh;
        msk  = (64'd1 << w) - 64'd1;
        ua   = {32'd0, m_a} & msk;
        ub   = {32'd0, m_b} & msk;
        sa   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        minv = -(longint'(1) << (w - 1));
        sh   = int'(ub[4:0]) & (w - 1);
        r    = 0;
        if (!m_md) begin
            case (m_alu)
                3'd0: r = ua + ub;
                3'd1: r = ua - ub;
                3'd2: r = ua & ub;
                3'd3: r = ua | ub;
                3'd4: r = ua ^ ub;
                3'd5: begin
                    if (m_f3 == 3'b010)      r = (sa < sb) ? 1 : 0;
                    else if (m_f3 == 3'b011) r = (ua < ub) ? 1 : 0;
                    else                     r = 0;
                end
                default: begin
                    if (!m_f3[2])  r = ua << sh;
                    else if (m_f7) r = sa >>> sh;
                    else           r = ua >> sh;
                end
            endcase
        end else begin
            case (m_f3)
                3'd0: begin p = sa * sb; r = p; end
                3'd1: begin p = sa * sb; r = $unsigned(p) >> w; end
                3'd2: begin p = sa * longint'(ub); r = $unsigned(p) >> w; end
                3'd3: r = (ua * ub) >> w;
                3'd4: begin
                    if (ub == 0)                      r = msk;
                    else if (sa == minv && sb == -1)  r = ua;
                    else                              r = sa / sb;
                end
                3'd5: r = (ub == 0) ? msk : ua / ub;
                3'd6: begin
                    if (ub == 0)                      r = ua;
                    else if (sa == minv && sb == -1)  r = 0;
                    else                              r = sa % sb;
                end
                default: r = (ub == 0) ? ua : ua % ub;
            endcase
        end
        return 32'(r & msk);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s (XLEN=%0d): got %h expected %h", tag, g_w, obs, expv);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu = 3'd0; f3 = 3'd0; f7 = 1'b0; md = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Present one op, push its expectation, measure latency, pop and compare.
    task automatic do_op(input string tag, input logic [2:0] t_alu, input logic [2:0] t_f3,
                         input logic t_f7, input logic t_md,
                         input logic [31:0] t_a, input logic [31:0] t_b, input int exp_lat);
        int lat;
        logic [31:0] expv;
        check({tag, " in_ready"}, 32'(obs_ready), 32'd1);
        alu = t_alu; f3 = t_f3; f7 = t_f7; md = t_md; a = t_a; b = t_b; in_valid = 1'b1;
        exp_q.push_back(model(g_w, t_alu, t_f3, t_f7, t_md, t_a, t_b));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!obs_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        expv = exp_q.pop_front();
        check({tag, " result"}, obs_result, expv);
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] msk, min_v, hi_nib, expv, ra, rb;
        logic [2:0]  rf3;
        int          lat, mlat;

        for (int pass = 0; pass < 2; pass++) begin
            g_w    = (pass == 0) ? 32 : 16;
            msk    = (g_w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            min_v  = 32'd1 << (g_w - 1);
            hi_nib = msk & ~((32'd1 << (g_w - 4)) - 32'd1);
            mlat   = g_w + 2;

            apply_reset();
            check("reset in_ready", 32'(obs_ready), 32'd1);
            check("reset out_valid", 32'(obs_valid), 32'd0);
            check("reset Result", obs_result, 32'd0);
            check("reset state", 32'(obs_state), 32'(IDLE));

            // Base ops.
            do_op("add overflow", ALU_ADD, 3'd0, 1'b0, 1'b0, min_v - 32'd1, 32'd1, 1);
            do_op("sra", ALU_SHF, 3'b101, 1'b1, 1'b0, hi_nib, 32'd4, 1);
            do_op("srl", ALU_SHF, 3'b101, 1'b0, 1'b0, hi_nib, 32'd4, 1);
            do_op("sll", 3'b111, 3'b001, 1'b0, 1'b0, 32'h0000_00A5, 32'd7, 1);
            do_op("sltu", ALU_CMP, CMP_SLTU, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 1);
            do_op("slt", ALU_CMP, CMP_SLT, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 1);
            do_op("cmp other", ALU_CMP, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 1);
            do_op("sub wrap", ALU_SUB, 3'd0, 1'b0, 1'b0, 32'd3, 32'd5, 1);
            for (int i = 0; i < 6; i++)
                do_op("rand base", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'b0, $urandom, $urandom, 1);

            // Multiply.
            do_op("mulh", MD_MULH, MD_MULH, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, mlat);
            do_op("mul", MD_MUL, MD_MUL, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, mlat);
            do_op("mulhu", 3'd0, MD_MULHU, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mlat);
            do_op("mulhsu", 3'd0, MD_MULHSU, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, mlat);

            // Divide, including the short-circuit cases.
            do_op("div", 3'd0, MD_DIV, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, mlat);
            do_op("rem", 3'd0, MD_REM, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, mlat);
            do_op("divu by zero", 3'd0, MD_DIVU, 1'b0, 1'b1, 32'd7, 32'd0, 2);
            do_op("rem by zero", 3'd0, MD_REM, 1'b0, 1'b1, 32'd5, 32'd0, 2);
            do_op("div overflow", 3'd0, MD_DIV, 1'b0, 1'b1, min_v, 32'hFFFF_FFFF, 2);
            do_op("rem overflow", 3'd0, MD_REM, 1'b0, 1'b1, min_v, 32'hFFFF_FFFF, 2);
            do_op("remu", 3'd0, MD_REMU, 1'b0, 1'b1, 32'd100, 32'd7, mlat);
            for (int i = 0; i < 6; i++) begin
                rf3 = 3'($urandom_range(0, 7));
                ra  = $urandom;
                rb  = (i == 5) ? 32'd0 : $urandom;
                lat = (rf3[2] && ((rb & msk) == 0)) ? 2 : mlat;
                do_op("rand md", 3'd0, rf3, 1'b0, 1'b1, ra, rb, lat);
            end

            // Backpressure: result held, in_valid ignored until handshake.
            check("bp in_ready", 32'(obs_ready), 32'd1);
            out_ready = 1'b0;
            alu = 3'd0; f3 = MD_DIVU; f7 = 1'b0; md = 1'b1; a = 32'd100; b = 32'd7; in_valid = 1'b1;
            exp_q.push_back(model(g_w, 3'd0, MD_DIVU, 1'b0, 1'b1, 32'd100, 32'd7));
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!obs_valid && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check("bp latency", 32'(lat), 32'(mlat));
            expv = exp_q.pop_front();
            check("bp constant 14", expv, 32'd14);
            for (int i = 0; i < 5; i++) begin
                check("bp out_valid held", 32'(obs_valid), 32'd1);
                check("bp Result held", obs_result, expv);
                check("bp in_ready low", 32'(obs_ready), 32'd0);
                md = 1'b0; alu = ALU_ADD; a = $urandom; b = $urandom; in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
            end
            check("bp Result after pulses", obs_result, expv);
            out_ready = 1'b1;
            @(negedge clk);
            check("bp handshake out_valid", 32'(obs_valid), 32'd0);
            check("bp handshake in_ready", 32'(obs_ready), 32'd1);
            @(negedge clk);
            check("bp nothing latched", 32'(obs_valid), 32'd0);

            // Reset in the middle of an iterative multiply.
            check("abort in_ready", 32'(obs_ready), 32'd1);
            md = 1'b1; f3 = MD_MUL; a = $urandom; b = $urandom; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (9) @(negedge clk);
            check("abort busy", 32'(obs_state), 32'(BUSY));
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("abort out_valid", 32'(obs_valid), 32'd0);
            check("abort in_ready after", 32'(obs_ready), 32'd1);
            check("abort Result", obs_result, 32'd0);
            repeat (3) @(negedge clk);
            check("abort no output", 32'(obs_valid), 32'd0);
            do_op("post-abort add", ALU_ADD, 3'd0, 1'b0, 1'b0, 32'd1234, 32'd4321, 1);
        end

        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
